// File: rtl/eq_match_tracker.sv
// eq_match_tracker: lock/unlock hysteresis tracker placed after the eq2 comparator.
// It declares lock after LOCK_N consecutive equal samples. It drops lock after
// UNLOCK_N consecutive unequal samples while locked. It also keeps saturating
// run-length, longest-run and mismatch statistics.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   clr          in   synchronous clear of FSM and statistics (same effect as reset)
//   in_valid     in   eq_in carries a sample this cycle
//   eq_in        in   comparator result, 1 = equal
//   locked       out  high in LOCKED and SLIP
//   lock_pulse   out  one-cycle strobe on SEARCH -> LOCKED
//   unlock_pulse out  one-cycle strobe on entry to SEARCH from LOCKED/SLIP
//   run_len      out  current consecutive-equal count (saturating)
//   max_run      out  largest run_len since reset/clr
//   miss_cnt     out  total unequal samples since reset/clr (saturating)
module eq_match_tracker #(
    parameter int unsigned LOCK_N   = 4,
    parameter int unsigned UNLOCK_N = 2,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          in_valid,
    input  logic          eq_in,
    output logic          locked,
    output logic          lock_pulse,
    output logic          unlock_pulse,
    output logic [CW-1:0] run_len,
    output logic [CW-1:0] max_run,
    output logic [CW-1:0] miss_cnt
);

    localparam int unsigned SW = (UNLOCK_N > 1) ? $clog2(UNLOCK_N + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_LOCKED,
        ST_SLIP
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] slip_q, slip_d;
    logic [CW-1:0] run_q, run_d;
    logic [CW-1:0] max_q, max_d;
    logic [CW-1:0] miss_q, miss_d;
    logic          locked_q, locked_d;
    logic          lock_pulse_q, lock_pulse_d;
    logic          unlock_pulse_q, unlock_pulse_d;

    // Unsaturated increments so that saturation never hides a threshold hit.
    logic [CW:0]   run_inc;
    logic [SW:0]   slip_inc;

    assign run_inc  = {1'b0, run_q} + (CW+1)'(1);
    assign slip_inc = {1'b0, slip_q} + (SW+1)'(1);

    // Next-state, statistics and pulse generation.
    always_comb begin
        state_d        = state_q;
        slip_d         = slip_q;
        run_d          = run_q;
        max_d          = max_q;
        miss_d         = miss_q;
        lock_pulse_d   = 1'b0;
        unlock_pulse_d = 1'b0;

        if (in_valid) begin
            if (eq_in) begin
                run_d = (run_q == CNT_MAX) ? run_q : run_inc[CW-1:0];
            end else begin
                run_d  = '0;
                miss_d = (miss_q == CNT_MAX) ? miss_q : miss_q + CW'(1);
            end
            max_d = (run_d > max_q) ? run_d : max_q;

            case (state_q)
                ST_SEARCH: begin
                    if (eq_in && (run_inc == (CW+1)'(LOCK_N))) begin
                        state_d      = ST_LOCKED;
                        lock_pulse_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!eq_in) begin
                        if (UNLOCK_N == 1) begin
                            state_d        = ST_SEARCH;
                            slip_d         = '0;
                            unlock_pulse_d = 1'b1;
                        end else begin
                            state_d = ST_SLIP;
                            slip_d  = SW'(1);
                        end
                    end
                end
                ST_SLIP: begin
                    if (eq_in) begin
                        state_d = ST_LOCKED;
                        slip_d  = '0;
                    end else if (slip_inc == (SW+1)'(UNLOCK_N)) begin
                        state_d        = ST_SEARCH;
                        slip_d         = '0;
                        unlock_pulse_d = 1'b1;
                    end else begin
                        slip_d = slip_inc[SW-1:0];
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    slip_d  = '0;
                end
            endcase
        end

        locked_d = (state_d != ST_SEARCH);
    end

    // State and output registers; clr behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_q        <= ST_SEARCH;
            slip_q         <= '0;
            run_q          <= '0;
            max_q          <= '0;
            miss_q         <= '0;
            locked_q       <= 1'b0;
            lock_pulse_q   <= 1'b0;
            unlock_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            slip_q         <= slip_d;
            run_q          <= run_d;
            max_q          <= max_d;
            miss_q         <= miss_d;
            locked_q       <= locked_d;
            lock_pulse_q   <= lock_pulse_d;
            unlock_pulse_q <= unlock_pulse_d;
        end
    end

    assign locked       = locked_q;
    assign lock_pulse   = lock_pulse_q;
    assign unlock_pulse = unlock_pulse_q;
    assign run_len      = run_q;
    assign max_run      = max_q;
    assign miss_cnt     = miss_q;

endmodule

// File: tb/tb_eq_match_tracker.sv
// Self-checking bench for eq_match_tracker: two instances (default parameters,
// and CW=3/LOCK_N=7) are compared every cycle against a behavioural model, with
// directed scenarios pinned by literal expectations and a randomized phase.
module tb_eq_match_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: defaults (LOCK_N=4, UNLOCK_N=2, CW=8). Index 1: LOCK_N=7, UNLOCK_N=2, CW=3.
    logic rst_s [2];
    logic clr_s [2];
    logic vld_s [2];
    logic eq_s  [2];

    logic       a_locked, a_lp, a_up;
    logic [7:0] a_run, a_max, a_miss;
    logic       b_locked, b_lp, b_up;
    logic [2:0] b_run, b_max, b_miss;

    eq_match_tracker u_a (
        .clk(clk), .reset(rst_s[0]), .clr(clr_s[0]), .in_valid(vld_s[0]), .eq_in(eq_s[0]),
        .locked(a_locked), .lock_pulse(a_lp), .unlock_pulse(a_up),
        .run_len(a_run), .max_run(a_max), .miss_cnt(a_miss)
    );

    eq_match_tracker #(.LOCK_N(7), .UNLOCK_N(2), .CW(3)) u_b (
        .clk(clk), .reset(rst_s[1]), .clr(clr_s[1]), .in_valid(vld_s[1]), .eq_in(eq_s[1]),
        .locked(b_locked), .lock_pulse(b_lp), .unlock_pulse(b_up),
        .run_len(b_run), .max_run(b_max), .miss_cnt(b_miss)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ln  [2] = '{4, 7};
    int un  [2] = '{2, 2};
    int sat [2] = '{255, 7};

    int m_locked [2];
    int m_misses [2];   // consecutive mismatches seen while locked
    int m_run    [2];
    int m_max    [2];
    int m_miss   [2];
    int m_lp     [2];
    int m_up     [2];

    task automatic model_step(input int i);
        m_lp[i] = 0;
        m_up[i] = 0;
        if (rst_s[i] || clr_s[i]) begin
            m_locked[i] = 0; m_misses[i] = 0; m_run[i] = 0; m_max[i] = 0; m_miss[i] = 0;
        end else if (vld_s[i]) begin
            if (eq_s[i]) begin
                if (m_locked[i] == 0 && m_run[i] + 1 == ln[i]) begin
                    m_locked[i] = 1;
                    m_lp[i]     = 1;
                end
                m_misses[i] = 0;
                m_run[i] = (m_run[i] + 1 > sat[i]) ? sat[i] : m_run[i] + 1;
            end else begin
                m_run[i]  = 0;
                m_miss[i] = (m_miss[i] + 1 > sat[i]) ? sat[i] : m_miss[i] + 1;
                if (m_locked[i] != 0) begin
                    m_misses[i]++;
                    if (m_misses[i] == un[i]) begin
                        m_locked[i] = 0;
                        m_misses[i] = 0;
                        m_up[i]     = 1;
                    end
                end
            end
            if (m_run[i] > m_max[i]) m_max[i] = m_run[i];
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // ---------------- per-cycle compare ----------------
    task automatic cmp_inst(input int i, input int lk, input int lp, input int up,
                            input int run, input int mx, input int ms);
        string p;
        p = (i == 0) ? "a" : "b";
        chk({p, ".locked"},       lk,  m_locked[i]);
        chk({p, ".lock_pulse"},   lp,  m_lp[i]);
        chk({p, ".unlock_pulse"}, up,  m_up[i]);
        chk({p, ".run_len"},      run, m_run[i]);
        chk({p, ".max_run"},      mx,  m_max[i]);
        chk({p, ".miss_cnt"},     ms,  m_miss[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, int'(a_locked), int'(a_lp), int'(a_up), int'(a_run), int'(a_max), int'(a_miss));
            cmp_inst(1, int'(b_locked), int'(b_lp), int'(b_up), int'(b_run), int'(b_max), int'(b_miss));
        end
    end

    // ---------------- drivers ----------------
    // Apply one cycle of inputs to both instances; returns at the next negedge.
    task automatic step(input bit ra, input bit ca, input bit va, input bit ea,
                        input bit rb, input bit cb, input bit vb, input bit eb);
        rst_s[0] = ra; clr_s[0] = ca; vld_s[0] = va; eq_s[0] = ea;
        rst_s[1] = rb; clr_s[1] = cb; vld_s[1] = vb; eq_s[1] = eb;
        @(negedge clk);
    endtask

    task automatic sa(input bit r, input bit c, input bit v, input bit e);
        step(r, c, v, e, 1'b0, 1'b0, 1'b0, 1'($urandom));
    endtask

    task automatic lit_a(input string tag, input int lk, input int lp, input int up,
                         input int run, input int mx, input int ms);
        chk({tag, " locked"},       int'(a_locked), lk);
        chk({tag, " lock_pulse"},   int'(a_lp),     lp);
        chk({tag, " unlock_pulse"}, int'(a_up),     up);
        chk({tag, " run_len"},      int'(a_run),    run);
        chk({tag, " max_run"},      int'(a_max),    mx);
        chk({tag, " miss_cnt"},     int'(a_miss),   ms);
    endtask

    bit last_eq [2];

    initial begin
        // Reset both instances.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        lit_a("reset", 0, 0, 0, 0, 0, 0);
        chk("b reset locked", int'(b_locked), 0);

        // Four equal samples lock on the 4th edge.
        for (int k = 1; k <= 3; k++) begin
            sa(1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("lock4 early lp k=%0d", k), int'(a_lp), 0);
            chk($sformatf("lock4 early locked k=%0d", k), int'(a_locked), 0);
        end
        sa(1'b0, 1'b0, 1'b1, 1'b1);
        lit_a("lock4", 1, 1, 0, 4, 4, 0);

        // 0,1,0,0 from LOCKED.
        sa(1'b0, 1'b0, 1'b1, 1'b0);
        lit_a("slip1", 1, 0, 0, 0, 4, 1);
        sa(1'b0, 1'b0, 1'b1, 1'b1);
        lit_a("relock", 1, 0, 0, 1, 4, 1);
        sa(1'b0, 1'b0, 1'b1, 1'b0);
        lit_a("slip2", 1, 0, 0, 0, 4, 2);
        sa(1'b0, 1'b0, 1'b1, 1'b0);
        lit_a("unlock", 0, 0, 1, 0, 4, 3);

        // 1,1,1,0,1,1,1,1 locks only at the 8th sample.
        sa(1'b0, 1'b1, 1'b0, 1'b0);
        lit_a("clr", 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            sa(1'b0, 1'b0, 1'b1, (k != 4));
            chk($sformatf("broken run lp k=%0d", k), int'(a_lp), 0);
        end
        sa(1'b0, 1'b0, 1'b1, 1'b1);
        lit_a("broken run lock", 1, 1, 0, 4, 4, 1);

        // Hold with in_valid=0 mid-run at run_len=2.
        sa(1'b0, 1'b1, 1'b0, 1'b0);
        sa(1'b0, 1'b0, 1'b1, 1'b1);
        sa(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            sa(1'b0, 1'b0, 1'b0, k[0]);
            lit_a($sformatf("hold k=%0d", k), 0, 0, 0, 2, 2, 0);
        end

        // Build miss_cnt=5 while staying locked, then clr with valid&!eq.
        sa(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) sa(1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            sa(1'b0, 1'b0, 1'b1, 1'b0);
            sa(1'b0, 1'b0, 1'b1, 1'b1);
        end
        lit_a("pre-clr", 1, 0, 0, 1, 4, 5);
        sa(1'b0, 1'b1, 1'b1, 1'b0);
        lit_a("clr w/ sample", 0, 0, 0, 0, 0, 0);

        // Reset in the middle of SLIP.
        for (int k = 0; k < 4; k++) sa(1'b0, 1'b0, 1'b1, 1'b1);
        sa(1'b0, 1'b0, 1'b1, 1'b0);
        lit_a("in slip", 1, 0, 0, 0, 4, 1);
        sa(1'b1, 1'b0, 1'b1, 1'b0);
        lit_a("reset in slip", 0, 0, 0, 0, 0, 0);

        // Saturation of run_len/max_run and miss_cnt at 255.
        for (int k = 0; k < 300; k++) sa(1'b0, 1'b0, 1'b1, 1'b1);
        lit_a("run sat", 1, 0, 0, 255, 255, 0);
        for (int k = 0; k < 300; k++) sa(1'b0, 1'b0, 1'b1, 1'b0);
        lit_a("miss sat", 0, 0, 0, 0, 255, 255);

        // CW=3, LOCK_N=7: lock on the 7th, saturate at 7 without wrap.
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("b lp k=%0d", k),     int'(b_lp),     (k == 7) ? 1 : 0);
            chk($sformatf("b locked k=%0d", k), int'(b_locked), (k >= 7) ? 1 : 0);
            chk($sformatf("b run k=%0d", k),    int'(b_run),    (k > 7) ? 7 : k);
            chk($sformatf("b max k=%0d", k),    int'(b_max),    (k > 7) ? 7 : k);
        end

        // Randomized phase: runs of equal/unequal samples, occasional clr/reset.
        last_eq[0] = 1'b1;
        last_eq[1] = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            bit r [2];
            bit c [2];
            bit v [2];
            for (int i = 0; i < 2; i++) begin
                r[i] = ($urandom_range(0, 299) == 0);
                c[i] = ($urandom_range(0, 149) == 0);
                v[i] = ($urandom_range(0, 99) < 80);
                if ($urandom_range(0, 99) < 20) last_eq[i] = ~last_eq[i];
            end
            step(r[0], c[0], v[0], v[0] ? last_eq[0] : 1'($urandom),
                 r[1], c[1], v[1], v[1] ? last_eq[1] : 1'($urandom));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
